bsg_gateway_reset_sequencer: RTL and testbench
==============================================

# bsg_gateway_reset_sequencer

Reset sequencer directly downstream of the gateway clock generator. Consumes the PLL lock indication (asynchronous to this block's clock), synchronizes it, and holds all gateway resets until lock has been stable for a programmable period. It then releases the resets in a fixed order: MicroBlaze, then IO master, then core. Any lock loss re-asserts every reset immediately and is counted in a saturating counter for firmware diagnostics.

## Interface
- sync_stages_p, 2: flops in the locked_i synchronizer; must be ≥ 2.
- lock_stable_cycles_p, 1024: consecutive synchronized-lock cycles required before the first release; must be ≥ 1.
- stage_delay_cycles_p, 256: cycles between successive reset releases; must be ≥ 1.
- clk_i  input  1  free-running clock from the buffered 150 MHz oscillator; never a PLL output.
- reset_n_i  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronous to clk_i (synchronized upstream).
- locked_i  input  1  PLL lock, asynchronous to clk_i.
- mb_reset_o  output  1  active-high MicroBlaze reset, registered.
- io_reset_o  output  1  active-high IO master reset, registered.
- core_reset_o  output  1  active-high core reset, registered.
- done_o  output  1  high once all resets are released.
- lock_loss_count_o  output  8  saturating count of lock losses after the MicroBlaze release.

## Operation
- Synchronizer: a sync_stages_p-deep flop chain on locked_i produces locked_sync.
- Counter: a single counter cnt, sized as clog2 of max(lock_stable_cycles_p, stage_delay_cycles_p). It is cleared on every state change.
- IDLE: all resets 1, done_o 0. Goes to LOCK_WAIT when locked_sync = 1.
- LOCK_WAIT: resets held. cnt increments each cycle.
  - At cnt = lock_stable_cycles_p−1: go to REL_MB.
  - locked_sync = 0: go to IDLE. The loss counter does not increment.
- REL_MB: mb_reset_o = 0. At cnt = stage_delay_cycles_p−1: go to REL_IO.
- REL_IO: mb_reset_o = 0, io_reset_o = 0. At cnt = stage_delay_cycles_p−1: go to DONE.
- DONE: all resets 0, done_o = 1. Stays until lock is lost.
- Lock loss:
  - In REL_MB, REL_IO or DONE, locked_sync = 0 goes to IDLE on the next edge.
  - All resets return to 1 and done_o to 0 on that same edge.
  - lock_loss_count_o increments, saturating at 255 and never wrapping.
- Outputs are decoded from registered state. Resets never release out of order and never glitch.
- Simultaneous events: loss takes priority over a terminal-count transition on the same edge.
- reset_n_i low, at any time and asynchronously:
  - Synchronizer cleared, state IDLE, cnt 0.
  - All three resets 1, done_o 0, lock_loss_count_o 0.

## Timing
- Edge 0 is the first clk_i edge that samples locked_i = 1, with locked_i held high from then on. S = sync_stages_p, N = lock_stable_cycles_p, D = stage_delay_cycles_p.
  - locked_sync rises after edge S−1; LOCK_WAIT is entered after edge S.
  - mb_reset_o falls after edge S+N.
  - io_reset_o falls after edge S+N+D.
  - core_reset_o falls and done_o rises after edge S+N+2D.
- A locked_i drop sampled at edge k re-asserts all resets after edge k+S.
- Reset values: mb_reset_o = io_reset_o = core_reset_o = 1, done_o = 0, lock_loss_count_o = 0.

## Test plan
- Nominal sequence (S=2, N=16, D=4; locked_i rises before edge 0) -> mb_reset_o falls after edge 18, io_reset_o after edge 22, core_reset_o and done_o after edge 26. Loss count stays 0.
- Lock glitch in LOCK_WAIT (locked_i low for 3 cycles at edge 10) -> all resets stay 1, count stays 0. The full N=16 wait restarts after relock.
- Lock loss in DONE -> all resets 1 and done_o 0 exactly S edges after the sampled drop, count 1. Relock repeats the nominal spacing.
- Lock loss at the same edge as the REL_IO terminal count -> IDLE is entered; core_reset_o is never released.
- 300 loss/relock cycles after the MicroBlaze release -> lock_loss_count_o saturates at 255.
- reset_n_i asserted mid REL_IO, between clock edges -> all resets 1, done_o 0 and count 0 immediately (asynchronously). Sequence restarts from IDLE after deassertion.

Source files
------------

// File: rtl/bsg_gateway_reset_sequencer_if.sv
// ==== bsg_gateway_reset_sequencer_if : PLL lock in, ordered gateway resets out -- rev 1.0 ====
`default_nettype none

interface bsg_gateway_reset_sequencer_if;
  logic       locked_i;
  logic       mb_reset_o;
  logic       io_reset_o;
  logic       core_reset_o;
  logic       done_o;
  logic [7:0] lock_loss_count_o;

  modport master (
    output locked_i,
    input  mb_reset_o, io_reset_o, core_reset_o, done_o, lock_loss_count_o
  );

  modport slave (
    input  locked_i,
    output mb_reset_o, io_reset_o, core_reset_o, done_o, lock_loss_count_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_gateway_reset_sequencer.sv
// ==== bsg_gateway_reset_sequencer : holds gateway resets until PLL lock is stable,
// ==== then releases MicroBlaze, IO master and core in order -- rev 1.0 ====
`default_nettype none

module bsg_gateway_reset_sequencer #(
  parameter int sync_stages_p        = 2,
  parameter int lock_stable_cycles_p = 1024,
  parameter int stage_delay_cycles_p = 256
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  bsg_gateway_reset_sequencer_if.slave         bus
);

  localparam int max_cycles = (lock_stable_cycles_p > stage_delay_cycles_p)
                              ? lock_stable_cycles_p : stage_delay_cycles_p;
  localparam int cnt_width  = (max_cycles > 1) ? $clog2(max_cycles) : 1;

  localparam logic [cnt_width-1:0] lock_last  = cnt_width'(lock_stable_cycles_p - 1);
  localparam logic [cnt_width-1:0] stage_last = cnt_width'(stage_delay_cycles_p - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOCK_WAIT = 3'd1,
    REL_MB    = 3'd2,
    REL_IO    = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [cnt_width-1:0]     cnt;
  logic [sync_stages_p-1:0] sync;
  logic                     locked_sync;
  logic                     lock_lost;
  logic                     mb_reset;
  logic                     io_reset;
  logic                     core_reset;
  logic                     done;
  logic [7:0]               loss_count;

  assign locked_sync = sync[sync_stages_p-1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync <= '0;
    end else begin
      sync <= {sync[sync_stages_p-2:0], bus.locked_i};
    end
  end

  always_comb begin
    state_next = state;
    lock_lost  = 1'b0;
    case (state)
      IDLE: begin
        if (locked_sync) state_next = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (!locked_sync)          state_next = IDLE;
        else if (cnt == lock_last) state_next = REL_MB;
      end
      REL_MB: begin
        lock_lost = !locked_sync;
        if (!locked_sync)           state_next = IDLE;
        else if (cnt == stage_last) state_next = REL_IO;
      end
      REL_IO: begin
        lock_lost = !locked_sync;
        if (!locked_sync)           state_next = IDLE;
        else if (cnt == stage_last) state_next = DONE;
      end
      DONE: begin
        lock_lost = !locked_sync;
        if (!locked_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state, glitch-free.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      mb_reset   <= 1'b1;
      io_reset   <= 1'b1;
      core_reset <= 1'b1;
      done       <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      state      <= state_next;
      mb_reset   <= !(state_next inside {REL_MB, REL_IO, DONE});
      io_reset   <= !(state_next inside {REL_IO, DONE});
      core_reset <= (state_next != DONE);
      done       <= (state_next == DONE);
      if (state_next != state) begin
        cnt <= '0;
      end else if (state inside {LOCK_WAIT, REL_MB, REL_IO}) begin
        cnt <= cnt + cnt_width'(1);
      end else begin
        cnt <= '0;
      end
      if (lock_lost && (loss_count != 8'hFF)) begin
        loss_count <= loss_count + 8'd1;
      end
    end
  end

  assign bus.mb_reset_o        = mb_reset;
  assign bus.io_reset_o        = io_reset;
  assign bus.core_reset_o      = core_reset;
  assign bus.done_o            = done;
  assign bus.lock_loss_count_o = loss_count;

endmodule

`default_nettype wire

// File: tb/tb_bsg_gateway_reset_sequencer.sv
// ==== tb_bsg_gateway_reset_sequencer : directed + random lock stimulus against a
// ==== behavioural release-time model -- rev 1.0 ====
`default_nettype none

module tb_bsg_gateway_reset_sequencer;

  localparam int S = 2;
  localparam int N = 16;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bsg_gateway_reset_sequencer_if bus ();

  bsg_gateway_reset_sequencer #(
    .sync_stages_p        (S),
    .lock_stable_cycles_p (N),
    .stage_delay_cycles_p (D)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 'elapsed' counts edges since the lock became stable-synchronized; each
  // reset is released once enough time has passed, and any loss drops back to inactive.
  bit m_active;
  int m_elapsed;
  int m_loss;
  bit m_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_elapsed = 0;
    m_loss    = 0;
    m_hist    = {};
    for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit ls;
    if (!rst_n) begin
      model_reset();
    end else begin
      ls = m_hist[0];
      if (!m_active) begin
        if (ls) begin
          m_active  = 1'b1;
          m_elapsed = 0;
        end
      end else if (!ls) begin
        if (m_elapsed >= N && m_loss < 255) m_loss++;
        m_active = 1'b0;
      end else if (m_elapsed < 1000000) begin
        m_elapsed++;
      end
      m_hist.push_back(bus.locked_i);
      m_hist.delete(0);
    end
  endtask

  task automatic check_outputs();
    bit mb_rel, io_rel, core_rel;
    mb_rel   = m_active && (m_elapsed >= N);
    io_rel   = m_active && (m_elapsed >= N + D);
    core_rel = m_active && (m_elapsed >= N + 2 * D);
    check("mb_reset",   32'(bus.mb_reset_o),        32'(!mb_rel));
    check("io_reset",   32'(bus.io_reset_o),        32'(!io_rel));
    check("core_reset", 32'(bus.core_reset_o),      32'(!core_rel));
    check("done",       32'(bus.done_o),            32'(core_rel));
    check("loss_count", 32'(bus.lock_loss_count_o), 32'(m_loss));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mb"},   32'(bus.mb_reset_o),        32'd1);
    check({tag, "_io"},   32'(bus.io_reset_o),        32'd1);
    check({tag, "_core"}, 32'(bus.core_reset_o),      32'd1);
    check({tag, "_done"}, 32'(bus.done_o),            32'd0);
    check({tag, "_cnt"},  32'(bus.lock_loss_count_o), 32'd0);
  endtask

  // Asynchronous reset pulse with lock low, released between edges.
  task automatic apply_reset();
    #2;
    rst_n        = 1'b0;
    bus.locked_i = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst");
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs n edges (edge 0 first) and records the edge after which each release appears.
  task automatic run_find(input int n, output int mb_e, output int io_e, output int core_e);
    mb_e = -1; io_e = -1; core_e = -1;
    for (int e = 0; e < n; e++) begin
      tick();
      if (mb_e < 0 && bus.mb_reset_o == 1'b0)     mb_e = e;
      if (io_e < 0 && bus.io_reset_o == 1'b0)     io_e = e;
      if (core_e < 0 && bus.core_reset_o == 1'b0 && bus.done_o == 1'b1) core_e = e;
    end
  endtask

  initial begin
    int mb_e, io_e, core_e, lat;
    bit core_seen;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.locked_i = 1'b0;
    model_reset();
    tick();
    tick();
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Nominal sequence.
    bus.locked_i = 1'b1;
    run_find(30, mb_e, io_e, core_e);
    check("nom_mb_edge", 32'(mb_e), 32'd18);
    check("nom_io_edge", 32'(io_e), 32'd22);
    check("nom_core_edge", 32'(core_e), 32'd26);

    // Lock loss in DONE: resets return exactly S edges after the sampled drop.
    bus.locked_i = 1'b0;
    lat = -1;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (lat < 0 && bus.mb_reset_o == 1'b1 && bus.core_reset_o == 1'b1) lat = e;
    end
    check("done_loss_latency", 32'(lat), 32'(S));
    check("done_loss_count", 32'(bus.lock_loss_count_o), 32'd1);
    bus.locked_i = 1'b1;
    run_find(30, mb_e, io_e, core_e);
    check("relock_mb_edge", 32'(mb_e), 32'd18);
    check("relock_io_edge", 32'(io_e), 32'd22);
    check("relock_core_edge", 32'(core_e), 32'd26);

    // Glitch during LOCK_WAIT: low for edges 10..12, full wait restarts.
    apply_reset();
    bus.locked_i = 1'b1;
    mb_e = -1;
    for (int e = 0; e < 40; e++) begin
      bus.locked_i = !(e >= 10 && e <= 12);
      tick();
      if (mb_e < 0 && bus.mb_reset_o == 1'b0) mb_e = e;
    end
    check("glitch_mb_edge", 32'(mb_e), 32'd31);
    check("glitch_count", 32'(bus.lock_loss_count_o), 32'd0);

    // Loss arrives on the same edge as the REL_IO terminal count.
    apply_reset();
    core_seen = 1'b0;
    for (int e = 0; e < 32; e++) begin
      bus.locked_i = (e < N + 2 * D);
      tick();
      if (bus.core_reset_o == 1'b0 || bus.done_o == 1'b1) core_seen = 1'b1;
    end
    check("tc_loss_core_never", 32'(core_seen), 32'd0);
    check("tc_loss_count", 32'(bus.lock_loss_count_o), 32'd1);

    // Asynchronous reset in the middle of REL_IO.
    apply_reset();
    bus.locked_i = 1'b1;
    for (int e = 0; e < 24; e++) tick();
    check("pre_async_io", 32'(bus.io_reset_o), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async");
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    run_find(30, mb_e, io_e, core_e);
    check("restart_mb_edge", 32'(mb_e), 32'd18);
    check("restart_core_edge", 32'(core_e), 32'd26);

    // 300 loss/relock cycles after the MicroBlaze release: count saturates.
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      bus.locked_i = 1'b1;
      for (int e = 0; e < S + N + 2; e++) tick();
      bus.locked_i = 1'b0;
      for (int e = 0; e < S + 1; e++) tick();
    end
    check("saturated_count", 32'(bus.lock_loss_count_o), 32'd255);

    // Random lock activity.
    apply_reset();
    for (int r = 0; r < 80; r++) begin
      bus.locked_i = 1'b1;
      for (int e = 0, len = $urandom_range(1, 45); e < len; e++) tick();
      bus.locked_i = 1'b0;
      for (int e = 0, len = $urandom_range(1, 6); e < len; e++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
